// File: rtl/cnn_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the CNN layer control path.
package cnn_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StConv   = 4'd2,
    StAct    = 4'd3,
    StPool   = 4'd4,
    StFc     = 4'd5,
    StOutput = 4'd6,
    StNext   = 4'd7,
    StDone   = 4'd8
  } state_t;

  function automatic int unsigned calc_out_w(int unsigned img_w, int unsigned k,
                                             int unsigned stride);
    return (img_w - k) / stride + 1;
  endfunction

  function automatic int unsigned calc_out_h(int unsigned img_h, int unsigned k,
                                             int unsigned stride);
    return (img_h - k) / stride + 1;
  endfunction

  // Counter/address width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/patch_counter.sv
// Nested col/row/kernel counters walking the output map; col fastest, kernel slowest.
module patch_counter
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned OUT_W     = 2,
  parameter int unsigned OUT_H     = 2,
  parameter int unsigned N_KERNELS = 2,
  parameter int unsigned COL_W     = clog2_min1(OUT_W),
  parameter int unsigned ROW_W     = clog2_min1(OUT_H),
  parameter int unsigned KSEL_W    = clog2_min1(N_KERNELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [KSEL_W-1:0] kernel,
  output logic              last
);

  localparam logic [COL_W-1:0]  ColMax = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]  RowMax = ROW_W'(OUT_H - 1);
  localparam logic [KSEL_W-1:0] KerMax = KSEL_W'(N_KERNELS - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [KSEL_W-1:0] kernel_q, kernel_d;

  assign last = (col_q == ColMax) && (row_q == RowMax) && (kernel_q == KerMax);

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    kernel_d = kernel_q;
    if (clear) begin
      col_d    = '0;
      row_d    = '0;
      kernel_d = '0;
    end else if (advance && !last) begin
      // Counters hold on the final patch so the last address stays visible.
      if (col_q == ColMax) begin
        col_d = '0;
        if (row_q == RowMax) begin
          row_d    = '0;
          kernel_d = kernel_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      kernel_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      kernel_q <= kernel_d;
    end
  end

  assign col    = col_q;
  assign row    = row_q;
  assign kernel = kernel_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Control FSM for one conv layer: walks a KxK window per kernel and strobes conv/pool/FC.
module cnn_layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W     = 4,
  parameter int unsigned IMG_H     = 4,
  parameter int unsigned K         = 3,
  parameter int unsigned STRIDE    = 1,
  parameter int unsigned N_KERNELS = 2,
  localparam int unsigned OUT_W    = calc_out_w(IMG_W, K, STRIDE),
  localparam int unsigned OUT_H    = calc_out_h(IMG_H, K, STRIDE),
  localparam int unsigned ADDR_W   = clog2_min1(IMG_W * IMG_H),
  localparam int unsigned KSEL_W   = clog2_min1(N_KERNELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              patch_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [KSEL_W-1:0] kernel_sel,
  output logic              load_conv,
  output logic              load_pool,
  output logic              load_fc,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned COL_W = clog2_min1(OUT_W);
  localparam int unsigned ROW_W = clog2_min1(OUT_H);

  state_t state_q, state_d;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [KSEL_W-1:0] kernel;
  logic              last;
  logic              cnt_clear;
  logic              cnt_advance;

  assign cnt_clear   = ((state_q == StIdle) && start && !abort) ||
                       ((state_q != StIdle) && abort);
  assign cnt_advance = (state_q == StNext) && !abort;

  patch_counter #(
    .OUT_W     (OUT_W),
    .OUT_H     (OUT_H),
    .N_KERNELS (N_KERNELS),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W),
    .KSEL_W    (KSEL_W)
  ) u_patch_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .col     (col),
    .row     (row),
    .kernel  (kernel),
    .last    (last)
  );

  // Top-left pixel of the current window in row-major image order.
  assign pixel_addr = ADDR_W'(row) * ADDR_W'(STRIDE * IMG_W) + ADDR_W'(col) * ADDR_W'(STRIDE);
  assign kernel_sel = kernel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (start && !abort) state_d = StFetch;
        StFetch:  state_d = StConv;
        StConv:   if (patch_valid) state_d = StAct;
        StAct:    state_d = StPool;
        StPool:   state_d = StFc;
        StFc:     state_d = StOutput;
        StOutput: if (out_ready) state_d = StNext;
        StNext:   state_d = last ? StDone : StFetch;
        StDone:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    load_conv = 1'b0;
    load_pool = 1'b0;
    load_fc   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state_q != StIdle);
    case (state_q)
      StConv:   load_conv = 1'b1;
      StPool:   load_pool = 1'b1;
      StFc:     load_fc   = 1'b1;
      StOutput: out_valid = 1'b1;
      StDone:   done      = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Parametrised control sequencer for one convolutional layer of the FPGA CNN datapath. It walks a K×K window over an IMG_W×IMG_H image with configurable stride, once per kernel. For each patch it drives the conv, pool and FC stages. It handshakes with the patch extractor upstream and the result sink downstream. It sits between the top-level start/host logic and the patch_extractor / conv / pool / FC units, and supersedes the fixed 4×4, single-kernel controller.

## Interface
- IMG_W, default 4: image width in pixels, ≥ K.
- IMG_H, default 4: image height in pixels, ≥ K.
- K, default 3: kernel edge size, ≥ 1.
- STRIDE, default 1: window step in both axes, ≥ 1.
- N_KERNELS, default 2: kernels applied sequentially, ≥ 1.
- Derived localparams:
  - OUT_W = (IMG_W−K)/STRIDE+1 and OUT_H = (IMG_H−K)/STRIDE+1, integer division.
  - ADDR_W = max(1, $clog2(IMG_W·IMG_H)).
  - KSEL_W = max(1, $clog2(N_KERNELS)).
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; returns all state and outputs to reset values.
- start  in  1  begins a layer pass; sampled only in IDLE.
- abort  in  1  synchronous cancel of an in-progress pass.
- patch_valid  in  1  patch_extractor reports the conv result for the current patch is ready.
- out_ready  in  1  downstream accepts the current result.
- pixel_addr  out  ADDR_W  linear address of the current patch's top-left pixel.
- kernel_sel  out  KSEL_W  current kernel index.
- load_conv  out  1  conv stage enable.
- load_pool  out  1  pool stage load strobe.
- load_fc  out  1  FC stage load strobe.
- out_valid  out  1  result available to downstream.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pass completes normally.

## Operation
- States (in order): IDLE, FETCH, CONV, ACT, POOL, FC, OUTPUT, NEXT, DONE.
- IDLE:
  - With start=1: clear col, row and kernel counters; go to FETCH.
  - start is ignored in every other state.
- FETCH: 1 cycle; pixel_addr is already stable.
- CONV: load_conv=1; stay until patch_valid=1, then go to ACT.
- ACT: 1 cycle, no outputs asserted.
- POOL: load_pool=1 for 1 cycle.
- FC: load_fc=1 for 1 cycle.
- OUTPUT: out_valid=1; stay until out_ready=1, then go to NEXT. Transfer occurs on out_valid&&out_ready.
- NEXT: advance the counters.
  - Loop order: col fastest, then row, then kernel.
  - col wraps at OUT_W−1, row wraps at OUT_H−1, kernel at N_KERNELS−1.
  - If the last patch (col=OUT_W−1, row=OUT_H−1, kernel=N_KERNELS−1) just finished: counters hold, go to DONE.
  - Otherwise: go to FETCH.
- DONE: done=1 for 1 cycle, then go to IDLE.
- pixel_addr = row·STRIDE·IMG_W + col·STRIDE, computed combinationally from registered counters. kernel_sel = kernel counter.
- Strobes are Moore outputs decoded from the state register only.
- Abort:
  - abort=1 in any non-IDLE state goes to IDLE next cycle and clears the counters.
  - done is not pulsed.
  - abort has priority over every other transition.
  - abort in IDLE has no effect. start and abort together in IDLE: abort wins, so the FSM stays IDLE.
- Reset values: state IDLE, counters 0, pixel_addr 0, kernel_sel 0. All strobes, out_valid, busy and done are 0.
- Reset mid-pass: everything returns to the reset values immediately (asynchronous); no done pulse.
- Illegal state encodings go to IDLE.

## Timing
- start sampled at edge 0 → FETCH from edge 1; pixel_addr for patch 0 is valid during that cycle.
- Minimum per-patch cycle count is 7 (FETCH, CONV, ACT, POOL, FC, OUTPUT, NEXT), with patch_valid and out_ready already high.
- Minimum pass length is 7·OUT_W·OUT_H·N_KERNELS + 1 (DONE) cycles after leaving IDLE.
- busy rises the cycle after start is accepted and falls the cycle after DONE.
- pixel_addr changes only on the edge that leaves NEXT.

## Structure
- Package cnn_ctrl_pkg:
  - state_t enum (4-bit) for the states above.
  - Helper functions for computing OUT_W and OUT_H.
- Sub-module patch_counter:
  - Parametrised by OUT_W, OUT_H and N_KERNELS.
  - Holds the nested col/row/kernel counters.
  - Inputs: clear, advance.
  - Outputs: col, row, kernel, last.
- The sequencer FSM and the address arithmetic live in cnn_layer_sequencer.

## Test plan
- Defaults (4×4, K=3, S=1, N=2), patch_valid and out_ready tied high:
  - pixel_addr sequence is 0,1,4,5,0,1,4,5.
  - kernel_sel is 0,0,0,0,1,1,1,1.
  - done pulses once, 57 cycles after FETCH entry.
  - load_conv, load_pool and load_fc each assert exactly 8 times.
- IMG 6×6, K=2, STRIDE=2, N=1 → addresses 0,2,4,12,14,16,24,26,28, then done.
- Backpressure:
  - Hold patch_valid low for 5 cycles in CONV → load_conv stays high for those 5 cycles, no state advance.
  - Hold out_ready low for 3 cycles → out_valid stays high and pixel_addr stays stable.
- Abort:
  - Assert abort during POOL of patch 3 → IDLE next cycle, busy=0, no done, counters 0.
  - A following start restarts at pixel_addr 0.
- Assert reset asynchronously mid-OUTPUT → all outputs 0 within the same cycle. start pulses during a busy pass are ignored.
- N_KERNELS=1, IMG=K=3 → exactly one patch at address 0, kernel_sel width 1, done after 8 cycles.
